pixel_framebuffer: RTL and testbench

Parametrised multi-channel pixel frame buffer for the camera path. Pixels are written from the camera capture side through an auto-incrementing, frame-aligned write pointer with per-channel write masking. They are read back by the J1 core or the display side with 1-cycle latency, using either random-address or sequential mode. Frame completion and frame count are reported, and a freeze control holds a captured frame.

---
 rtl/pixel_framebuffer.sv | 121 ++++++++++++
 tb/tb_pixel_framebuffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_framebuffer.sv
// Multi-channel pixel frame buffer: frame-aligned masked writes, random or sequential reads with 1-cycle latency.
// Write side stalls only while freeze is high; the read side never stalls and returns old data on address collisions.
module pixel_framebuffer #(
  parameter int CH_W   = 8,
  parameter int NCH    = 3,
  parameter int DEPTH  = 10000,
  parameter int AW     = 16,
  parameter int FCNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  freeze_i,
  input  logic                  wr_sof_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [CH_W*NCH-1:0]   wr_data_i,
  input  logic [NCH-1:0]        wr_chmask_i,
  input  logic                  rd_en_i,
  input  logic                  rd_seq_i,
  input  logic                  rd_rewind_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic                  rd_valid_o,
  output logic [CH_W*NCH-1:0]   rd_data_o,
  output logic [AW-1:0]         wr_ptr_o,
  output logic                  frame_done_o,
  output logic [FCNT_W-1:0]     frame_cnt_o
);

  localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]     DEPTH_X = (AW + 1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic              wr_fire;
  logic [AW-1:0]     wr_addr;
  logic              wr_last;
  logic [AW-1:0]     rd_addr;
  logic              rd_oor;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;

  assign wr_ready_o = ~freeze_i;
  assign wr_fire    = wr_valid_i & ~freeze_i;
  // Start-of-frame forces the pixel to address 0, abandoning any partial frame.
  assign wr_addr    = wr_sof_i ? '0 : wr_ptr_q;
  assign wr_last    = (wr_addr == LAST);
  assign rd_addr    = rd_seq_i ? rd_ptr_q : rd_addr_i;
  assign rd_oor     = ({1'b0, rd_addr} >= DEPTH_X);
  assign wr_idx     = wr_addr[IW-1:0];
  assign rd_idx     = rd_addr[IW-1:0];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    frame_done_d = 1'b0;
    if (wr_fire) begin
      wr_ptr_d     = wr_last ? '0 : wr_addr + AW'(1);
      frame_done_d = wr_last;
    end
    frame_cnt_d = frame_cnt_q + FCNT_W'(frame_done_d);
  end

  // Rewind wins over advance; the read in the same cycle still uses the old pointer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (rd_rewind_i) begin
      rd_ptr_d = '0;
    end else if (rd_en_i && rd_seq_i) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    rd_valid_d = rd_en_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CH_W-1:0] mem [0:DEPTH-1];
    logic [CH_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (!rst_i && wr_fire && wr_chmask_i[k]) begin
        mem[wr_idx] <= wr_data_i[k*CH_W +: CH_W];
      end
    end

    // Registered read port; sees pre-write contents on a same-cycle collision.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_q <= '0;
      end else if (rd_en_i) begin
        rd_q <= rd_oor ? '0 : mem[rd_idx];
      end
    end

    assign rd_data_o[k*CH_W +: CH_W] = rd_q;
  end

  assign rd_valid_o   = rd_valid_q;
  assign wr_ptr_o     = wr_ptr_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Bench for pixel_framebuffer (DEPTH=16 build): directed scenarios then randomized traffic against a frame-level model.
module tb_pixel_framebuffer;
  localparam int CH_W = 8, NCH = 3, PW = CH_W*NCH, DEPTH = 16, AW = 16, FCNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, freeze = 1'b0, wr_sof = 1'b0, wr_valid = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic [NCH-1:0] wr_chmask = '0;
  logic rd_en = 1'b0, rd_seq = 1'b0, rd_rewind = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic wr_ready, rd_valid, frame_done;
  logic [PW-1:0] rd_data;
  logic [AW-1:0] wr_ptr;
  logic [FCNT_W-1:0] frame_cnt;

  pixel_framebuffer #(.CH_W(CH_W), .NCH(NCH), .DEPTH(DEPTH), .AW(AW), .FCNT_W(FCNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .wr_sof_i(wr_sof), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_chmask_i(wr_chmask), .rd_en_i(rd_en),
    .rd_seq_i(rd_seq), .rd_rewind_i(rd_rewind), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .wr_ptr_o(wr_ptr), .frame_done_o(frame_done), .frame_cnt_o(frame_cnt)
  );

  int n_tests = 0, n_fail = 0;

  // Reference model: whole pixels per address, integer pointers.
  logic [PW-1:0] m_mem [DEPTH];
  int m_wptr = 0, m_rptr = 0, m_fcnt = 0;
  bit m_done = 0, m_rvalid = 0;
  logic [PW-1:0] m_rdata = '0;

  // Apply current inputs to the model, then clock the DUT; returns 1 time unit after the edge.
  task automatic step();
    int a, ra;
    if (rst) begin
      m_wptr = 0; m_rptr = 0; m_rvalid = 0; m_rdata = '0; m_done = 0; m_fcnt = 0;
    end else begin
      m_rvalid = rd_en;
      if (rd_en) begin
        ra = rd_seq ? m_rptr : int'(rd_addr);
        m_rdata = (ra >= DEPTH) ? '0 : m_mem[ra];
      end
      if (rd_rewind) m_rptr = 0;
      else if (rd_en && rd_seq) m_rptr = (m_rptr + 1) % DEPTH;
      m_done = 0;
      if (wr_valid && !freeze) begin
        a = wr_sof ? 0 : m_wptr;
        for (int k = 0; k < NCH; k++)
          if (wr_chmask[k]) m_mem[a][k*CH_W +: CH_W] = wr_data[k*CH_W +: CH_W];
        m_wptr = (a + 1) % DEPTH;
        if (a == DEPTH - 1) begin m_done = 1; m_fcnt = (m_fcnt + 1) % (1 << FCNT_W); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_valid = 0; wr_sof = 0; rd_en = 0; rd_seq = 0; rd_rewind = 0; rst = 0; freeze = 0;
  endtask

  task automatic wr(input bit sof, input logic [PW-1:0] d, input logic [NCH-1:0] m);
    wr_valid = 1; wr_sof = sof; wr_data = d; wr_chmask = m;
    step();
    wr_valid = 0; wr_sof = 0;
  endtask

  task automatic rd_rand(input int a);
    rd_en = 1; rd_seq = 0; rd_addr = AW'(a);
    step();
    rd_en = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); rst = 0;
    n_tests++; if (wr_ptr !== '0) begin n_fail++; $display("FAIL reset_wr_ptr: got %0d want 0", wr_ptr); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_tests++; if (frame_done !== 1'b0 || frame_cnt !== '0) begin n_fail++; $display("FAIL reset_frame: got done=%b cnt=%0d want 0/0", frame_done, frame_cnt); end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 5; i++) wr(i == 0, 24'h0A0B0C + PW'(i), 3'b111);
    n_tests++; if (wr_ptr !== 16'd5) begin n_fail++; $display("FAIL wr_ptr_after5: got %0d want 5", wr_ptr); end
    for (int i = 0; i < 5; i++) begin
      rd_rand(i);
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== 24'h0A0B0C + PW'(i))
        begin n_fail++; $display("FAIL rd_addr%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 24'h0A0B0C + PW'(i)); end
    end
    step();
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== 24'h0A0B10)
      begin n_fail++; $display("FAIL rd_hold: got v=%b d=%h want v=0 d=0a0b10", rd_valid, rd_data); end
  endtask

  task automatic test_chmask();
    for (int i = 0; i < 7; i++) wr(i == 0, PW'($urandom), 3'b000);
    n_tests++; if (wr_ptr !== 16'd7) begin n_fail++; $display("FAIL zero_mask_ptr: got %0d want 7", wr_ptr); end
    wr(0, 24'h112233, 3'b111);
    for (int i = 0; i < 7; i++) wr(i == 0, PW'($urandom), 3'b000);
    wr(0, 24'hFFFFFF, 3'b010);
    rd_rand(7);
    n_tests++; if (rd_data !== 24'h11FF33) begin n_fail++; $display("FAIL chmask_merge: got %h want 11ff33", rd_data); end
    rd_rand(3);
    n_tests++; if (rd_data !== 24'h0A0B0F) begin n_fail++; $display("FAIL zero_mask_keep: got %h want 0a0b0f", rd_data); end
    n_tests++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL partial_no_count: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_frame_wrap();
    int pulses = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr(i == 0, 24'hC00000 | PW'(i), 3'b111);
      if (frame_done === 1'b1) pulses++;
      n_tests++; if (frame_done !== (i == DEPTH - 1))
        begin n_fail++; $display("FAIL frame_done_w%0d: got %b want %b", i, frame_done, i == DEPTH - 1); end
    end
    n_tests++; if (frame_cnt !== 8'd1 || wr_ptr !== '0 || pulses != 1)
      begin n_fail++; $display("FAIL frame_end: got cnt=%0d ptr=%0d pulses=%0d want 1/0/1", frame_cnt, wr_ptr, pulses); end
    step();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_len: got %b want 0", frame_done); end
    wr(0, 24'hABCDEF, 3'b111);
    rd_rand(0);
    n_tests++; if (rd_data !== 24'hABCDEF) begin n_fail++; $display("FAIL wrap_addr0: got %h want abcdef", rd_data); end
  endtask

  task automatic test_freeze();
    freeze = 1; wr_valid = 1; wr_data = 24'h777777; wr_chmask = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_ready: got %b want 0", wr_ready); end
      rd_en = 1; rd_addr = 16'd1;
      step();
      n_tests++; if (wr_ptr !== 16'd1 || rd_valid !== 1'b1 || rd_data !== 24'hC00001)
        begin n_fail++; $display("FAIL freeze_hold: got ptr=%0d v=%b d=%h want 1/1/c00001", wr_ptr, rd_valid, rd_data); end
    end
    idle();
    #1;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL unfreeze_ready: got %b want 1", wr_ready); end
    wr(0, 24'h555555, 3'b111);
    rd_rand(1);
    n_tests++; if (rd_data !== 24'h555555 || wr_ptr !== 16'd2)
      begin n_fail++; $display("FAIL resume: got d=%h ptr=%0d want 555555/2", rd_data, wr_ptr); end
  endtask

  task automatic test_seq_read();
    logic [PW-1:0] exp_seq [4];
    exp_seq[0] = 24'hABCDEF; exp_seq[1] = 24'h555555; exp_seq[2] = 24'hC00002; exp_seq[3] = 24'hC00003;
    rd_rewind = 1; step(); rd_rewind = 0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; rd_seq = 1; rd_rewind = (i == 3);
      step();
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== exp_seq[i])
        begin n_fail++; $display("FAIL seq_rd%0d: got v=%b d=%h want 1/%h", i, rd_valid, rd_data, exp_seq[i]); end
    end
    rd_rewind = 0; step();
    n_tests++; if (rd_data !== 24'hABCDEF) begin n_fail++; $display("FAIL after_rewind: got %h want abcdef", rd_data); end
    idle();
    wr_valid = 1; wr_data = 24'h246802; wr_chmask = 3'b111; rd_en = 1; rd_addr = 16'd2;
    step(); idle();
    n_tests++; if (rd_data !== 24'hC00002) begin n_fail++; $display("FAIL read_first: got %h want c00002", rd_data); end
    rd_rand(2);
    n_tests++; if (rd_data !== 24'h246802) begin n_fail++; $display("FAIL after_collide: got %h want 246802", rd_data); end
  endtask

  task automatic test_reset_inflight();
    rd_rand(5);
    n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b want 1", rd_valid); end
    rst = 1; step(); rst = 0;
    n_tests++; if (rd_valid !== 1'b0 || rd_data !== '0 || wr_ptr !== '0 || frame_cnt !== '0)
      begin n_fail++; $display("FAIL rst_inflight: got v=%b d=%h ptr=%0d cnt=%0d want 0/0/0/0", rd_valid, rd_data, wr_ptr, frame_cnt); end
    rd_rand(DEPTH - 1);
    n_tests++; if (rd_data !== 24'hC0000F) begin n_fail++; $display("FAIL rd_last: got %h want c0000f", rd_data); end
    rd_rand(DEPTH);
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== '0)
      begin n_fail++; $display("FAIL rd_oor: got v=%b d=%h want 1/0", rd_valid, rd_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(63, 0) == 0);
      freeze    = ($urandom_range(3, 0) == 0);
      wr_valid  = ($urandom_range(3, 0) != 0);
      wr_sof    = ($urandom_range(15, 0) == 0);
      wr_data   = PW'($urandom);
      wr_chmask = NCH'($urandom);
      rd_en     = $urandom_range(1, 0) == 1;
      rd_seq    = $urandom_range(1, 0) == 1;
      rd_rewind = ($urandom_range(15, 0) == 0);
      rd_addr   = AW'($urandom_range(DEPTH + 3, 0));
      #1;
      n_tests++; if (wr_ready !== !freeze) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, wr_ready, !freeze); end
      step();
      n_tests++; if (rd_valid !== m_rvalid || rd_data !== m_rdata)
        begin n_fail++; $display("FAIL rnd_rd c%0d: got v=%b d=%h want v=%b d=%h", c, rd_valid, rd_data, m_rvalid, m_rdata); end
      n_tests++; if (wr_ptr !== AW'(m_wptr) || frame_done !== m_done || frame_cnt !== FCNT_W'(m_fcnt))
        begin n_fail++; $display("FAIL rnd_wr c%0d: got ptr=%0d done=%b cnt=%0d want %0d/%b/%0d", c, wr_ptr, frame_done, frame_cnt, m_wptr, m_done, m_fcnt); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_chmask();
    test_frame_wrap();
    test_freeze();
    test_seq_read();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
